// File: rtl/iob_eth_rx_fcs.sv
// Receive-side FCS checker: runs CRC-32 over every frame byte, strips the 4 FCS
// bytes through a delay line and reports per-frame status plus saturating counters.
module iob_eth_rx_fcs #(
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    input  logic        rx_abort_i,
    input  logic        clr_cnt_i,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    output logic        out_last_o,
    output logic        frame_done_o,
    output logic        crc_ok_o,
    output logic        crc_err_o,
    output logic        short_err_o,
    output logic [15:0] len_o,
    output logic        abort_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PASS
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       occ_q, occ_d;
    logic [31:0]      crc_q, crc_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [3:0][7:0]  dl_q, dl_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             short_q, short_d;
    logic [15:0]      len_q, len_d;
    logic             abort_q, abort_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic [31:0]      crc_nx;
    logic [15:0]      cnt_inc;

    // MSB-first shift fed LSB-first data: the bit-reversed image of the
    // reflected Ethernet CRC, hence the C704DD7B residue.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : '0);
        end
        return r;
    endfunction

    assign crc_nx  = crc_next(crc_q, rx_data_i);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        dl_d        = dl_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        done_d      = 1'b0;
        ok_d        = ok_q;
        err_d       = err_q;
        short_d     = short_q;
        len_d       = len_q;
        abort_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (rx_abort_i) begin
            state_d = IDLE;
            occ_d   = '0;
            crc_d   = '1;
            cnt_d   = '0;
            abort_d = 1'b1;
        end else if (rx_valid_i) begin
            dl_d = {dl_q[2:0], rx_data_i};
            if (state_q == PASS) begin
                out_valid_d = 1'b1;
                out_data_d  = dl_q[3];
            end
            if (rx_last_i) begin
                state_d = IDLE;
                occ_d   = '0;
                crc_d   = '1;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (state_q == PASS) begin
                    out_last_d = 1'b1;
                    ok_d       = (crc_nx == RESIDUE);
                    err_d      = (crc_nx != RESIDUE);
                    short_d    = 1'b0;
                    len_d      = cnt_inc - 16'd4;
                end else begin
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    short_d = 1'b1;
                    len_d   = '0;
                end
            end else begin
                crc_d = crc_nx;
                cnt_d = cnt_inc;
                if (state_q != PASS) begin
                    occ_d   = occ_q + 3'd1;
                    state_d = (occ_q == 3'd3) ? PASS : FILL;
                end
            end
        end

        if (clr_cnt_i) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else if (done_d) begin
            if (frame_cnt_q != '1)
                frame_cnt_d = frame_cnt_q + 16'd1;
            if ((err_d || short_d) && (err_cnt_q != '1))
                err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            crc_q       <= '1;
            cnt_q       <= '0;
            dl_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            short_q     <= 1'b0;
            len_q       <= '0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            dl_q        <= dl_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            short_q     <= short_d;
            len_q       <= len_d;
            abort_q     <= abort_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign frame_done_o = done_q;
    assign crc_ok_o     = ok_q;
    assign crc_err_o    = err_q;
    assign short_err_o  = short_q;
    assign len_o        = len_q;
    assign abort_o      = abort_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_iob_eth_rx_fcs.sv
// Bench for iob_eth_rx_fcs: frames carry a reference CRC-32 FCS; a scoreboard
// compares emitted payload bytes and per-frame status against a frame-level model.
module tb_iob_eth_rx_fcs;

    logic        clk = 1'b0;
    logic        arst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i, rx_last_i, rx_abort_i, clr_cnt_i;
    logic [7:0]  out_data_o;
    logic        out_valid_o, out_last_o, frame_done_o;
    logic        crc_ok_o, crc_err_o, short_err_o, abort_o;
    logic [15:0] len_o, frame_cnt_o, err_cnt_o;

    always #5 clk = ~clk;

    iob_eth_rx_fcs #(.RESIDUE(32'hC704DD7B)) dut (
        .clk_i       (clk),
        .arst_i      (arst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_last_i   (rx_last_i),
        .rx_abort_i  (rx_abort_i),
        .clr_cnt_i   (clr_cnt_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_last_o  (out_last_o),
        .frame_done_o(frame_done_o),
        .crc_ok_o    (crc_ok_o),
        .crc_err_o   (crc_err_o),
        .short_err_o (short_err_o),
        .len_o       (len_o),
        .abort_o     (abort_o),
        .frame_cnt_o (frame_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    typedef struct {
        logic        ok;
        logic        err;
        logic        sh;
        logic [15:0] len;
        logic        lst;
        logic [15:0] fc;
        logic [15:0] ec;
    } rec_t;

    rec_t        got_r[$], exp_r[$];
    logic [8:0]  got_b[$], exp_b[$];   // {last, data}
    logic [7:0]  pl_q[$], fr_q[$];
    int          nvec = 0, nerr = 0, nabort = 0;
    int          exp_fc = 0, exp_ec = 0;
    bit          capture = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard reflected CRC-32 with final inversion: the value transmitted as FCS.
    function automatic logic [31:0] crc32(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic rand_payload(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
    endtask

    task automatic build(input bit corrupt);
        logic [31:0] c;
        fr_q = pl_q;
        c = crc32(pl_q);
        for (int k = 0; k < 4; k++) fr_q.push_back(c[8*k +: 8]);
        if (corrupt) fr_q[fr_q.size() - 2] = fr_q[fr_q.size() - 2] ^ 8'h01;
    endtask

    task automatic send(input int gapmax, input bit clr);
        int          n;
        logic [7:0]  pl[$];
        logic [31:0] fcs;
        rec_t        r;
        n = fr_q.size();
        if (n >= 5) begin
            for (int i = 0; i < n - 4; i++) begin
                pl.push_back(fr_q[i]);
                if (capture) exp_b.push_back({(i == n - 5), fr_q[i]});
            end
            fcs   = {fr_q[n-1], fr_q[n-2], fr_q[n-3], fr_q[n-4]};
            r.ok  = (fcs == crc32(pl));
            r.err = !r.ok;
            r.sh  = 1'b0;
            r.len = 16'(n - 4);
            r.lst = 1'b1;
        end else begin
            r.ok = 1'b0; r.err = 1'b0; r.sh = 1'b1; r.len = '0; r.lst = 1'b0;
        end
        if (clr) begin
            exp_fc = 0;
            exp_ec = 0;
        end else begin
            if (exp_fc < 65535) exp_fc++;
            if ((r.err || r.sh) && exp_ec < 65535) exp_ec++;
        end
        r.fc = 16'(exp_fc);
        r.ec = 16'(exp_ec);
        if (capture) exp_r.push_back(r);
        for (int i = 0; i < n; i++) begin
            if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
            rx_data_i  = fr_q[i];
            rx_valid_i = 1'b1;
            rx_last_i  = (i == n - 1);
            clr_cnt_i  = clr && (i == n - 1);
            @(negedge clk);
            rx_valid_i = 1'b0;
            rx_last_i  = 1'b0;
            clr_cnt_i  = 1'b0;
        end
    endtask

    // Drives the first k bytes of fr_q with no last; the first k-4 come out.
    task automatic send_partial(input int k);
        for (int i = 0; i < k; i++) begin
            if (i >= 4) exp_b.push_back({1'b0, fr_q[i-4]});
            rx_data_i  = fr_q[i];
            rx_valid_i = 1'b1;
            @(negedge clk);
            rx_valid_i = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        logic [8:0] gb, eb;
        rec_t       g, e;
        repeat (3) @(negedge clk);
        chk({tag, ":nbytes"}, got_b.size(), exp_b.size());
        chk({tag, ":nframes"}, got_r.size(), exp_r.size());
        while (got_b.size() > 0 && exp_b.size() > 0) begin
            gb = got_b.pop_front();
            eb = exp_b.pop_front();
            chk({tag, ":byte"}, gb, eb);
        end
        while (got_r.size() > 0 && exp_r.size() > 0) begin
            g = got_r.pop_front();
            e = exp_r.pop_front();
            chk({tag, ":crc_ok"}, g.ok, e.ok);
            chk({tag, ":crc_err"}, g.err, e.err);
            chk({tag, ":short_err"}, g.sh, e.sh);
            chk({tag, ":len"}, g.len, e.len);
            chk({tag, ":last_at_done"}, g.lst, e.lst);
            chk({tag, ":frame_cnt"}, g.fc, e.fc);
            chk({tag, ":err_cnt"}, g.ec, e.ec);
        end
        got_b.delete(); exp_b.delete(); got_r.delete(); exp_r.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":out_data"}, out_data_o, 0);
        chk({tag, ":out_valid"}, out_valid_o, 0);
        chk({tag, ":out_last"}, out_last_o, 0);
        chk({tag, ":frame_done"}, frame_done_o, 0);
        chk({tag, ":crc_ok"}, crc_ok_o, 0);
        chk({tag, ":crc_err"}, crc_err_o, 0);
        chk({tag, ":short_err"}, short_err_o, 0);
        chk({tag, ":len"}, len_o, 0);
        chk({tag, ":abort"}, abort_o, 0);
        chk({tag, ":frame_cnt"}, frame_cnt_o, 0);
        chk({tag, ":err_cnt"}, err_cnt_o, 0);
    endtask

    always @(negedge clk) begin : monitor
        rec_t r;
        if (capture && !arst_i) begin
            if (out_valid_o) got_b.push_back({out_last_o, out_data_o});
            if (frame_done_o) begin
                r.ok  = crc_ok_o;
                r.err = crc_err_o;
                r.sh  = short_err_o;
                r.len = len_o;
                r.lst = out_last_o & out_valid_o;
                r.fc  = frame_cnt_o;
                r.ec  = err_cnt_o;
                got_r.push_back(r);
            end
            if (abort_o) nabort++;
        end
    end

    initial begin
        int a0;
        arst_i = 1'b1;
        rx_data_i = '0; rx_valid_i = 1'b0; rx_last_i = 1'b0;
        rx_abort_i = 1'b0; clr_cnt_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        arst_i = 1'b0;
        @(negedge clk);

        // 64-byte frame, payload 0x00..0x3B, good then corrupted FCS
        pl_q.delete();
        for (int i = 0; i < 60; i++) pl_q.push_back(8'(i));
        build(1'b0); send(0, 1'b0); compare("f64");
        build(1'b1); send(0, 1'b0); compare("f64bad");

        fr_q.delete();
        for (int i = 0; i < 3; i++) fr_q.push_back(8'($urandom));
        send(0, 1'b0); compare("short3");

        // back to back, gaps inside the second frame
        rand_payload($urandom_range(20, 40)); build(1'b0); send(0, 1'b0);
        rand_payload($urandom_range(20, 40)); build(1'b0); send(3, 1'b0);
        compare("b2b");

        // abort after 10 bytes, coincident with a valid byte
        a0 = nabort;
        rand_payload(20); build(1'b0);
        send_partial(10);
        rx_abort_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'($urandom);
        @(negedge clk);
        rx_abort_i = 1'b0; rx_valid_i = 1'b0;
        rand_payload(16); build(1'b0); send(0, 1'b0);
        compare("abort");
        chk("abort:pulses", nabort - a0, 1);

        // 4-byte (short) vs 5-byte boundary
        fr_q.delete();
        for (int i = 0; i < 4; i++) fr_q.push_back(8'($urandom));
        send(0, 1'b0);
        rand_payload(1); build(1'b0); send(0, 1'b0);
        build(1'b1); send(0, 1'b0);
        compare("bound");

        for (int f = 0; f < 20; f++) begin
            rand_payload($urandom_range(0, 40));
            build($urandom_range(0, 3) == 0);
            send($urandom_range(0, 2), 1'b0);
            if ($urandom_range(0, 1) == 1) compare("rand");
        end
        compare("rand");

        // counter saturation with back-to-back single-byte frames
        capture = 1'b0;
        fr_q.delete();
        fr_q.push_back(8'hA5);
        repeat (65536) send(0, 1'b0);
        repeat (2) @(negedge clk);
        capture = 1'b1;
        chk("sat:frame_cnt", frame_cnt_o, 16'hFFFF);
        chk("sat:err_cnt", err_cnt_o, 16'hFFFF);
        send(0, 1'b0);
        compare("sat");

        // clear coincident with an increment
        rand_payload(8); build(1'b0); send(0, 1'b1);
        compare("clr");
        chk("clr:frame_cnt", frame_cnt_o, 0);
        chk("clr:err_cnt", err_cnt_o, 0);

        // asynchronous reset mid-frame
        rand_payload(12); build(1'b0); send(0, 1'b0);
        rand_payload(12); build(1'b0);
        send_partial(7);
        #2 arst_i = 1'b1;
        #1 chk_zero("midrst");
        exp_fc = 0;
        exp_ec = 0;
        @(negedge clk);
        arst_i = 1'b0;
        @(negedge clk);
        rand_payload(10); build(1'b0); send(0, 1'b0);
        compare("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
